// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, enable levels,
// the fetch FSM encoding and the buffered-entry layout.
package pc_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    localparam logic [0:0] FETCH_IDLE = 1'b0;
    localparam logic [0:0] FETCH_RUN  = 1'b1;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO holding fetched {pc, inst} entries. Flush and keep-head act on
// the contents left after a same-cycle pop; a push is applied after either.
module fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic         keep_head_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_base;
    logic [CW-1:0] count_q, count_d, count_base;

    always_comb begin
        rd_d = rd_q + AW'(pop_i);
        if (flush_i) begin
            wr_base    = rd_d;
            count_base = '0;
        end else if (keep_head_i) begin
            wr_base    = rd_d + AW'(1);
            count_base = CW'(1);
        end else begin
            wr_base    = wr_q;
            count_base = count_q - CW'(pop_i);
        end
        wr_d    = wr_base + AW'(push_i);
        count_d = count_base + CW'(push_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which slots hold valid data.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_base] <= data_i;
        end
    end

    assign head_o  = mem[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, ROM interface and a small decode buffer.
// Optional macro FETCH_DELAY_SLOT_EN keeps one delay-slot instruction on redirect.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   rom_ce_o,
    output logic [InstAddrBus-1:0] rom_addr_o,
    input  logic [InstBus-1:0]     rom_inst_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [0:0]             state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] branch_pc;
    logic [CW-1:0]          count;
    fetch_entry_t           head, push_entry;
    logic                   in_run, pop, has_space;
    logic                   push, flush, keep_head;
    logic                   unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target_i[1:0];
    assign branch_pc          = {branch_target_i[InstAddrBus-1:2], 2'b00};

    assign in_run     = (state_q == FETCH_RUN);
    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o && id_ready_i;
    assign has_space  = (count < CW'(BUF_DEPTH)) || pop;
    assign rom_ce_o   = (in_run && has_space) ? ChipEnable : ChipDisable;
    assign rom_addr_o = pc_q;
    assign push_entry = '{pc: pc_q, inst: rom_inst_i};

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        push      = 1'b0;
        flush     = 1'b0;
        keep_head = 1'b0;
        if (in_run) begin
            if (branch_flag_i) begin
`ifdef FETCH_DELAY_SLOT_EN
                // The entry left at the head after this cycle's pop becomes the delay slot.
                if ((count - CW'(pop)) != '0) begin
                    keep_head = 1'b1;
                end else begin
                    flush = 1'b1;
                    push  = rom_ce_o;
                end
`else
                flush = 1'b1;
`endif
            end else begin
                push = rom_ce_o;
            end
        end
    end

    always_comb begin
        state_d = FETCH_RUN;
        pc_d    = pc_q;
        if (branch_flag_i) begin
            pc_d = branch_pc;
        end else if (push) begin
            pc_d = pc_q + InstAddrBus'(4);
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .keep_head_i (keep_head),
        .data_i      (push_entry),
        .head_o      (head),
        .count_o     (count)
    );

    assign id_pc_o   = id_valid_o ? head.pc   : ZeroWord;
    assign id_inst_o = id_valid_o ? head.inst : ZeroWord;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch against a queue-based model of the fetch rules.
module tb_pc_fetch;

    localparam int BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // ROM word n holds the value n.
    assign rom_inst_i = rom_addr_o >> 2;

    pc_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_valid_o      (id_valid_o),
        .id_ready_i      (id_ready_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_run;

    function automatic logic [97:0] expected_vec();
        bit valid, pop, ce;
        valid = mq.size() != 0;
        pop   = valid && id_ready_i;
        ce    = m_run && (mq.size() < BUF_DEPTH || pop);
        return {ce, m_pc, valid, valid ? mq[0].pc : 32'h0, valid ? mq[0].inst : 32'h0};
    endfunction

    function automatic logic [97:0] actual_vec();
        return {rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_run = 0;
    endtask

    task automatic model_edge();
        bit   pop, ce;
        ent_t e;
        pop = mq.size() != 0 && id_ready_i;
        ce  = m_run && (mq.size() < BUF_DEPTH || pop);
        if (pop) void'(mq.pop_front());
        if (!m_run) begin
            if (branch_flag_i) m_pc = branch_target_i & ~32'h3;
            m_run = 1;
        end else if (branch_flag_i) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (mq.size() > 0) begin
                e = mq[0];
                mq.delete();
                mq.push_back(e);
            end else if (ce) begin
                mq.push_back('{pc: m_pc, inst: m_pc >> 2});
            end
`else
            mq.delete();
`endif
            m_pc = branch_target_i & ~32'h3;
        end else if (ce) begin
            mq.push_back('{pc: m_pc, inst: m_pc >> 2});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive(input logic b, input logic [31:0] t, input logic r);
        branch_flag_i   = b;
        branch_target_i = t;
        id_ready_i      = r;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b1);
        total_cnt++; if (rom_ce_o !== 1'b0) $display("FAIL reset_ce got %b want 0", rom_ce_o); else pass_cnt++;
        total_cnt++; if (id_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", id_valid_o); else pass_cnt++;
        total_cnt++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) $display("FAIL reset_head got %h/%h want 0/0", id_pc_o, id_inst_o); else pass_cnt++;
        total_cnt++; if (rom_addr_o !== 32'h0) $display("FAIL reset_addr got %h want 0", rom_addr_o); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_startup();
        apply_reset();
        drive(1'b0, 32'h0, 1'b1);
        total_cnt++; if (rom_ce_o !== 1'b0) $display("FAIL idle_ce got %b want 0", rom_ce_o); else pass_cnt++;
        tick();
        total_cnt++; if ({rom_ce_o, rom_addr_o, id_valid_o} !== {1'b1, 32'h0, 1'b0}) $display("FAIL start_fetch0 got %b/%h/%b want 1/0/0", rom_ce_o, rom_addr_o, id_valid_o); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({id_valid_o, id_pc_o, id_inst_o, rom_addr_o} !== {1'b1, 32'(k * 4), 32'(k), 32'(k * 4 + 4)})
                $display("FAIL start_deliver%0d got %b %h/%h addr %h want 1 %h/%h addr %h", k, id_valid_o, id_pc_o, id_inst_o, rom_addr_o, k * 4, k, k * 4 + 4);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({rom_ce_o, rom_addr_o, id_valid_o, id_pc_o} !== {1'b0, 32'h8, 1'b1, 32'h0})
                $display("FAIL stall%0d got ce %b addr %h valid %b pc %h want 0 8 1 0", k, rom_ce_o, rom_addr_o, id_valid_o, id_pc_o);
            else pass_cnt++;
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        total_cnt++; if (rom_ce_o !== 1'b1) $display("FAIL release_ce got %b want 1", rom_ce_o); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if ({id_valid_o, id_pc_o} !== {1'b1, 32'(k * 4)}) $display("FAIL release_pc%0d got %b/%h want 1/%h", k, id_valid_o, id_pc_o, k * 4);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] want0, want1;
        apply_reset();
        drive(1'b1, 32'h10, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        total_cnt++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h10}) $display("FAIL idle_branch got %b/%h want 1/10", rom_ce_o, rom_addr_o); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if ({rom_ce_o, id_pc_o, rom_addr_o} !== {1'b0, 32'h10, 32'h18}) $display("FAIL redir_full got %b/%h/%h want 0/10/18", rom_ce_o, id_pc_o, rom_addr_o); else pass_cnt++;
        drive(1'b1, 32'h103, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
`ifdef FETCH_DELAY_SLOT_EN
        total_cnt++; if ({id_valid_o, id_pc_o} !== {1'b1, 32'h10}) $display("FAIL redir_slot got %b/%h want 1/10", id_valid_o, id_pc_o); else pass_cnt++;
        want0 = 32'h10; want1 = 32'h100;
`else
        total_cnt++; if (id_valid_o !== 1'b0) $display("FAIL redir_flush got %b want 0", id_valid_o); else pass_cnt++;
        want0 = 32'h100; want1 = 32'h104;
`endif
        total_cnt++; if (rom_addr_o !== 32'h100) $display("FAIL redir_addr got %h want 100", rom_addr_o); else pass_cnt++;
        drive(1'b0, 32'h0, 1'b1);
        if (!id_valid_o) tick();
        total_cnt++; if ({id_valid_o, id_pc_o} !== {1'b1, want0}) $display("FAIL redir_first got %b/%h want 1/%h", id_valid_o, id_pc_o, want0); else pass_cnt++;
        tick();
        total_cnt++; if ({id_valid_o, id_pc_o} !== {1'b1, want1}) $display("FAIL redir_second got %b/%h want 1/%h", id_valid_o, id_pc_o, want1); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1'b0, 32'h0, 1'b1);
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total_cnt++;
        if (actual_vec() !== 98'h0) $display("FAIL async_rst got ce %b addr %h valid %b %h/%h want all 0", rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1);
            total_cnt++;
            if (actual_vec() !== expected_vec()) $display("FAIL async_restart%0d got %h want %h", k, actual_vec(), expected_vec());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1'b1, 32'hFFFF_FFFC, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        total_cnt++; if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_pre got %b/%h want 1/fffffffc", rom_ce_o, rom_addr_o); else pass_cnt++;
        tick();
        total_cnt++;
        if ({rom_addr_o, id_pc_o, id_inst_o} !== {32'h0, 32'hFFFF_FFFC, 32'h3FFF_FFFF})
            $display("FAIL wrap_post got addr %h head %h/%h want 0 fffffffc/3fffffff", rom_addr_o, id_pc_o, id_inst_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1'b0, 32'h0, 1'b1);
        repeat (4) tick();
        drive(1'b1, 32'h200, 1'b1);
        tick();
        drive(1'b1, 32'h300, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        total_cnt++; if (rom_addr_o !== 32'h300) $display("FAIL b2b_addr got %h want 300", rom_addr_o); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (actual_vec() !== expected_vec()) $display("FAIL b2b_seq%0d got %h want %h", k, actual_vec(), expected_vec());
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 8) == 0, $urandom, ($urandom % 3) != 0);
            total_cnt++;
            if (actual_vec() !== expected_vec()) begin
                if (errs < 10) $display("FAIL random%0d got %h want %h", k, actual_vec(), expected_vec());
                errs++;
            end else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
